dmem_io_responder: RTL and testbench
====================================

# dmem_io_responder

Data-side responder for the pipelined core's memory-stage port. It presents a word-addressed data RAM and a single memory-mapped I/O word at 0xFFFFFFFC to the core's dmem interface. Reads are combinational because the core samples read data at the end of its memory stage; writes commit on the clock edge. The I/O word drives the board LEDs and returns synchronised switches plus sticky push-button events, targeting the DE2-115.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width; RAM depth is 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- dmem_addr  in  32  byte address from the core. Bits [1:0] are ignored.
- dmem_dataout  in  32  write data from the core.
- dmem_rw  in  1  RAM write strobe, 1 = write this cycle.
- io_rw  in  1  I/O-word write strobe, 1 = write this cycle.
- dmem_datain  out  32  read data returned to the core.
- io_sw  in  18  slide switches, asynchronous.
- io_key  in  4  push buttons, asynchronous, active-low (idle 1).
- io_led  out  32  LED register.

## Operation
Address decode:
- iosel = &dmem_addr[31:2].
- RAM index = dmem_addr[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses alias modulo the depth.

Read path (combinational):
- When iosel = 1: dmem_datain = {key_evt[3:0], 10'b0, sw_s2[17:0]}.
- When iosel = 0: dmem_datain = ram[index].
- There is no read strobe. Reads have no side effects.

RAM write:
- At a rising edge with dmem_rw = 1: ram[index] <= dmem_dataout.
- The write does not check iosel; the core already gates dmem_rw against iosel.

I/O write:
- At a rising edge with io_rw = 1: io_led <= dmem_dataout.
- In the same edge, key_evt bits are cleared where dmem_dataout[31:28] = 1 (write-1-to-clear).
- dmem_rw and io_rw asserted together: both writes execute independently.

Switch synchroniser:
- Two flops: sw_s1 <= io_sw, sw_s2 <= sw_s1.

Key path:
- Three flop stages per bit: key_s1 <= io_key, key_s2 <= key_s1, key_d <= key_s2.
- key_fall = key_d & ~key_s2.
- key_evt <= (key_evt & ~clr) | key_fall, where clr = io_rw ? dmem_dataout[31:28] : 4'b0.
- A set on the same edge as a clear wins: the bit ends at 1.

State per key bit: IDLE (evt = 0) -> PENDING on key_fall -> IDLE on a W1C write without a simultaneous key_fall.

Reset (asynchronous, on reset_n low):
- io_led = 0, key_evt = 0, sw_s1 = sw_s2 = 0.
- key_s1 = key_s2 = key_d = 4'hF (idle-high, so releasing reset creates no spurious event).
- RAM contents are not reset.
- dmem_datain remains a combinational function of the address and the registers above.
- A reset asserted mid-write discards that write's I/O effect. The RAM word being written is undefined.

## Timing
- Read latency: 0 cycles. dmem_datain is valid in the same cycle as dmem_addr.
- Write to read: a write at edge N is visible to combinational reads from the cycle after N. A same-cycle read of the address being written returns the old data.
- io_led changes on the edge at which io_rw is sampled high.
- Switch change reaches the read word 2 rising edges after it becomes stable.
- Key press (io_key bit 1 -> 0) before edge P1: key_fall is high between P2 and P3, and key_evt is set at P3. A key held low sets the event only once. A release creates no event.
- There is no back-pressure or stall output. The core's STALL stays 0.

## Test plan
- Reset: hold reset_n = 0 with io_key = 4'hF, then release. Require io_led = 0 and a read of 0xFFFFFFFC = {4'h0, 10'b0, io_sw} after 2 edges. key_evt stays 0.
- RAM: write 0xDEADBEEF to 0x00000010. Require a same-cycle read of that address to return the old value and the next cycle to return 0xDEADBEEF. A read of 0x00001010 with ADDR_W = 10 aliases and returns 0xDEADBEEF.
- I/O write: io_rw = 1, dmem_dataout = 0x0000A5A5. Require io_led = 0x0000A5A5 after the edge and RAM unchanged.
- Key event: drive io_key[2] low at edge 0. Require read bit 30 = 1 from edge 3 onward and held while the key is held. Release the key: bit stays 1. Write 0x40000000 via io_rw: bit clears and io_led = 0x40000000.
- Set/clear collision: time a W1C write of bit 28 on the exact edge at which key_fall[0] is high. Require key_evt[0] = 1 afterward.
- Async reset: pulse reset_n low between edges while key_evt = 4'hF and io_led = 0xFFFFFFFF. Require both to be 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_io_responder.sv
// rtl/dmem_io_responder.sv - core dmem responder: word RAM plus one memory-mapped I/O word
// The I/O word at 0xFFFFFFFC drives the LEDs and returns synchronised switches and sticky key events.
module dmem_io_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_dataout,
  input  logic        dmem_rw,
  input  logic        io_rw,
  output logic [31:0] dmem_datain,
  input  logic [17:0] io_sw,
  input  logic [3:0]  io_key,
  output logic [31:0] io_led
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       r_ram [DEPTH];
  logic [31:0]       r_io_led;
  logic [17:0]       r_sw_s1;
  logic [17:0]       r_sw_s2;
  logic [3:0]        r_key_s1;
  logic [3:0]        r_key_s2;
  logic [3:0]        r_key_d;
  logic [3:0]        r_key_evt;

  logic              w_iosel;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_key_fall;
  logic [3:0]        w_clr;
  logic              w_unused_addr;

  assign w_iosel       = &dmem_addr[31:2];
  assign w_idx         = dmem_addr[ADDR_W+1:2];
  assign w_unused_addr = ^dmem_addr[1:0];

  // Keys are active-low, so a press shows up as a 1->0 transition past the synchroniser.
  assign w_key_fall = r_key_d & ~r_key_s2;
  assign w_clr      = io_rw ? dmem_dataout[31:28] : 4'b0;

  assign dmem_datain = w_iosel ? {r_key_evt, 10'b0, r_sw_s2} : r_ram[w_idx];
  assign io_led      = r_io_led;

  // RAM contents survive reset; the core gates dmem_rw against iosel itself.
  always_ff @(posedge clk) begin
    if (dmem_rw) begin
      r_ram[w_idx] <= dmem_dataout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_io_led  <= 32'h0;
      r_sw_s1   <= 18'h0;
      r_sw_s2   <= 18'h0;
      r_key_s1  <= 4'hF;
      r_key_s2  <= 4'hF;
      r_key_d   <= 4'hF;
      r_key_evt <= 4'h0;
    end else begin
      r_sw_s1   <= io_sw;
      r_sw_s2   <= r_sw_s1;
      r_key_s1  <= io_key;
      r_key_s2  <= r_key_s1;
      r_key_d   <= r_key_s2;
      // A fall on the same edge as a clear keeps the event pending.
      r_key_evt <= (r_key_evt & ~w_clr) | w_key_fall;
      if (io_rw) begin
        r_io_led <= dmem_dataout;
      end
    end
  end

endmodule

// File: tb/tb_dmem_io_responder.sv
// tb/tb_dmem_io_responder.sv - directed scoreboard bench for dmem_io_responder
module tb_dmem_io_responder;

  localparam logic [31:0] IO_ADDR = 32'hFFFF_FFFC;
  localparam logic [17:0] SW      = 18'h2A5A5;

  logic        clk;
  logic        reset_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_dataout;
  logic        dmem_rw;
  logic        io_rw;
  logic [31:0] dmem_datain;
  logic [17:0] io_sw;
  logic [3:0]  io_key;
  logic [31:0] io_led;

  logic [31:0] sb[$];
  int          n_pass;
  int          n_fail;
  int          n_total;

  dmem_io_responder #(.ADDR_W(10)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dmem_addr    (dmem_addr),
    .dmem_dataout (dmem_dataout),
    .dmem_rw      (dmem_rw),
    .io_rw        (io_rw),
    .dmem_datain  (dmem_datain),
    .io_sw        (io_sw),
    .io_key       (io_key),
    .io_led       (io_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] io_word(input logic [3:0] evt, input logic [17:0] sw);
    return {evt, 10'b0, sw};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] exp);
    sb.push_back(exp);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    reset_n = 1'b0; dmem_addr = IO_ADDR; dmem_dataout = 32'h0;
    dmem_rw = 1'b0; io_rw = 1'b0; io_sw = SW; io_key = 4'hF;
    tick(); tick();

    // reset release, switches arrive two edges later
    reset_n = 1'b1;
    #1; push(32'h0); check("rst_led", io_led);
    push(io_word(4'h0, 18'h0)); check("rst_io_0", dmem_datain);
    tick();
    push(io_word(4'h0, 18'h0)); check("rst_io_1", dmem_datain);
    tick();
    push(io_word(4'h0, SW)); check("rst_io_2", dmem_datain);

    // RAM write, same-cycle old data, aliasing
    dmem_addr = 32'h10; dmem_dataout = 32'h1111_1111; dmem_rw = 1'b1;
    tick();
    dmem_dataout = 32'hDEAD_BEEF;
    #1; push(32'h1111_1111); check("ram_old", dmem_datain);
    tick();
    dmem_rw = 1'b0;
    #1; push(32'hDEAD_BEEF); check("ram_new", dmem_datain);
    dmem_addr = 32'h1010;
    #1; push(32'hDEAD_BEEF); check("ram_alias", dmem_datain);

    // I/O write
    dmem_addr = IO_ADDR; dmem_dataout = 32'h0000_A5A5; io_rw = 1'b1;
    #1; push(32'h0); check("led_before", io_led);
    tick();
    io_rw = 1'b0;
    #1; push(32'h0000_A5A5); check("led_after", io_led);
    dmem_addr = 32'h10;
    #1; push(32'hDEAD_BEEF); check("ram_untouched", dmem_datain);
    dmem_addr = IO_ADDR;

    // key[2] press: event appears at the third edge
    io_key = 4'b1011;
    tick();
    #1; push(io_word(4'h0, SW)); check("key_p1", dmem_datain);
    tick();
    #1; push(io_word(4'h0, SW)); check("key_p2", dmem_datain);
    tick();
    #1; push(io_word(4'h4, SW)); check("key_p3", dmem_datain);
    tick(); tick(); tick();
    #1; push(io_word(4'h4, SW)); check("key_held", dmem_datain);
    io_key = 4'hF;
    tick(); tick(); tick(); tick();
    #1; push(io_word(4'h4, SW)); check("key_released", dmem_datain);
    dmem_dataout = 32'h4000_0000; io_rw = 1'b1;
    tick();
    io_rw = 1'b0;
    #1; push(io_word(4'h0, SW)); check("key_w1c", dmem_datain);
    push(32'h4000_0000); check("key_w1c_led", io_led);

    // set/clear collision on key[0]: W1C lands on the edge where key_fall[0] is high
    io_key = 4'b1110;
    tick(); tick();
    dmem_dataout = 32'h1000_0000; io_rw = 1'b1;
    tick();
    io_rw = 1'b0;
    #1; push(io_word(4'h1, SW)); check("collide_set_wins", dmem_datain);
    push(32'h1000_0000); check("collide_led", io_led);
    io_rw = 1'b1;
    tick();
    io_rw = 1'b0;
    #1; push(io_word(4'h0, SW)); check("collide_later_clear", dmem_datain);
    io_key = 4'hF;
    tick(); tick(); tick();
    #1; push(io_word(4'h0, SW)); check("release_no_evt", dmem_datain);

    // async reset with all events pending and LEDs full
    dmem_dataout = 32'hFFFF_FFFF; io_rw = 1'b1;
    tick();
    io_rw = 1'b0;
    io_key = 4'h0;
    tick(); tick(); tick();
    #1; push(io_word(4'hF, SW)); check("all_evt", dmem_datain);
    push(32'hFFFF_FFFF); check("all_led", io_led);
    #1; reset_n = 1'b0;
    #1; push(32'h0); check("async_led", io_led);
    push(32'h0); check("async_io", dmem_datain);
    io_key = 4'hF;
    dmem_addr = 32'h10;
    #1; push(32'hDEAD_BEEF); check("ram_survives_rst", dmem_datain);
    tick();
    reset_n = 1'b1;
    dmem_addr = IO_ADDR;
    tick(); tick(); tick();
    #1; push(io_word(4'h0, SW)); check("post_rst_clean", dmem_datain);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
